ws2812_multi_tx: RTL and testbench

- Dedicated multi-channel WS2812/NeoPixel serializer. It is the hard-wired, parametrised successor to running the WS2812 program on a PIO state machine.
- CHANNELS independent strings are driven. Each channel has its own word FIFO and bit-timing FSM.
- Pixel width (GRB 24 / RGBW 32), bit timings and latch gap are set by parameters.
- Sits on the same host action bus as the PIO block and drives GPIO pins directly.

---
 rtl/ws2812_pkg.sv | 27 ++
 rtl/ws2812_chan.sv | 172 +++++++++++++++++
 rtl/ws2812_multi_tx.sv | 62 ++++++
 tb/tb_ws2812_multi_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state type, default 25 MHz timings and counter sizing for ws2812_multi_tx.
`default_nettype none

package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_T0H    = 10;
    localparam int DEF_T1H    = 20;
    localparam int DEF_TBIT   = 31;
    localparam int DEF_TRESET = 1250;

    // One counter serves both bit timing and the latch gap, so size it for the larger.
    function automatic int cnt_width(input int tbit, input int treset);
        int longest;
        longest = (tbit > treset) ? tbit : treset;
        return $clog2(longest + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_chan.sv
// ws2812_chan: one WS2812 string - word FIFO plus bit-timing FSM; dout is uninverted.
`default_nettype none

module ws2812_chan
    import ws2812_pkg::*;
#(
    parameter int BITS   = 24,
    parameter int DEPTH  = 8,
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TBIT   = DEF_TBIT,
    parameter int TRESET = DEF_TRESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        push,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        ovf,
    output logic        dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(TBIT, TRESET);
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] HI0_END   = CW'(T0H - 1);
    localparam logic [CW-1:0] HI1_END   = CW'(T1H - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(TBIT - 1);
    localparam logic [CW-1:0] LATCH_END = CW'(TRESET - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          accept;
    logic          pop;
    logic [31:0]   head;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [BW-1:0] bitcnt;
    logic [BW-1:0] bitcnt_n;
    logic [31:0]   shreg;
    logic [31:0]   shreg_n;

    // A full FIFO drops the push even when the FSM pops on the same edge.
    assign accept = push && !full;
    assign head   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
            if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            dout   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            // Both lag the state by one clock, which keeps them mutually aligned.
            dout   <= (state == HIGH);
            busy   <= (state != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_n  = head;
                    bitcnt_n = BIT_LAST;
                    cnt_n    = '0;
                    state_n  = HIGH;
                end
            end
            HIGH: begin
                cnt_n = cnt + 1'b1;
                if (cnt == (shreg[31] ? HI1_END : HI0_END)) begin
                    state_n = LOW;
                end
            end
            LOW: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (bitcnt != '0) begin
                        shreg_n  = shreg << 1;
                        bitcnt_n = bitcnt - 1'b1;
                        state_n  = HIGH;
                    end else if (!empty) begin
                        // Chain the next queued word with no gap.
                        pop      = 1'b1;
                        shreg_n  = head;
                        bitcnt_n = BIT_LAST;
                        state_n  = HIGH;
                    end else begin
                        state_n = LATCH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LATCH: begin
                if (cnt == LATCH_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ws2812_multi_tx.sv
// ws2812_multi_tx: CHANNELS independent WS2812 serializers behind one push/ch write port.
`default_nettype none

module ws2812_multi_tx
    import ws2812_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 24,
    parameter int DEPTH    = 8,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET,
    parameter int INVERT   = 0
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [31:0]                                         din,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch,
    input  logic                                                push,
    output logic [CHANNELS-1:0]                                 full,
    output logic [CHANNELS-1:0]                                 empty,
    output logic [CHANNELS-1:0]                                 busy,
    output logic [CHANNELS-1:0]                                 ovf,
    output logic [CHANNELS-1:0]                                 dout
);

    localparam int   CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic INV = (INVERT != 0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic push_sel;
        logic raw_dout;

        // ch values at or beyond CHANNELS match no instance and are ignored.
        assign push_sel = push && (ch == CHW'(i));

        ws2812_chan #(
            .BITS   (BITS),
            .DEPTH  (DEPTH),
            .T0H    (T0H),
            .T1H    (T1H),
            .TBIT   (TBIT),
            .TRESET (TRESET)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .din   (din),
            .push  (push_sel),
            .full  (full[i]),
            .empty (empty[i]),
            .busy  (busy[i]),
            .ovf   (ovf[i]),
            .dout  (raw_dout)
        );

        assign dout[i] = raw_dout ^ INV;
    end

endmodule

`default_nettype wire

// File: tb/tb_ws2812_multi_tx.sv
// tb_ws2812_multi_tx: waveform-decoding scoreboard bench for ws2812_multi_tx (plain and inverted instances).
`timescale 1ns/1ps
`default_nettype none

module tb_ws2812_multi_tx;

    localparam int CH     = 4;
    localparam int BITS   = 24;
    localparam int DEPTH  = 4;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 20;
    localparam int LIMIT  = 3000;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        push  = 1'b0;
    logic [31:0] din   = '0;
    logic [1:0]  ch    = '0;

    logic [CH-1:0] full, empty, busy, ovf, dout;
    logic [CH-1:0] full_i, empty_i, busy_i, ovf_i, dout_i;

    always #5 clk = ~clk;

    ws2812_multi_tx #(
        .CHANNELS(CH), .BITS(BITS), .DEPTH(DEPTH), .T0H(T0H), .T1H(T1H),
        .TBIT(TBIT), .TRESET(TRESET), .INVERT(0)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .ch(ch), .push(push),
        .full(full), .empty(empty), .busy(busy), .ovf(ovf), .dout(dout)
    );

    ws2812_multi_tx #(
        .CHANNELS(CH), .BITS(BITS), .DEPTH(DEPTH), .T0H(T0H), .T1H(T1H),
        .TBIT(TBIT), .TRESET(TRESET), .INVERT(1)
    ) dut_inv (
        .clk(clk), .reset(reset), .din(din), .ch(ch), .push(push),
        .full(full_i), .empty(empty_i), .busy(busy_i), .ovf(ovf_i), .dout(dout_i)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected words per channel, consumed by the waveform decoder.
    logic [31:0] expq [CH][$];
    int          hcnt [CH];
    int          bitn [CH];
    int          rises [CH];
    int          last_rise [CH];
    bit          prevd [CH];
    bit          valid [CH];
    logic [23:0] acc [CH];
    int          inv_bad = 0;
    int          mon_d;
    logic [31:0] mon_e;

    initial begin
        for (int c = 0; c < CH; c++) begin
            rises[c] = 0;
            last_rise[c] = 0;
        end
    end

    always @(negedge clk) begin
        if (dout_i !== ~dout) inv_bad++;
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                hcnt[c]  = 0;
                bitn[c]  = 0;
                prevd[c] = 1'b0;
                valid[c] = 1'b0;
                expq[c].delete();
            end else begin
                if (dout[c] && !prevd[c]) begin
                    if (valid[c]) begin
                        mon_d = cyc - last_rise[c];
                        if (bitn[c] != 0)
                            chk(mon_d == TBIT, "bit_period", mon_d, TBIT);
                        else
                            chk(mon_d == TBIT || mon_d >= TBIT + TRESET + 1, "word_gap", mon_d, TBIT + TRESET + 1);
                    end
                    rises[c]++;
                    last_rise[c] = cyc;
                    valid[c] = 1'b1;
                    hcnt[c] = 1;
                end else if (dout[c]) begin
                    hcnt[c]++;
                end else if (prevd[c]) begin
                    chk(hcnt[c] == T0H || hcnt[c] == T1H, "high_time", hcnt[c], T1H);
                    acc[c] = {acc[c][22:0], (hcnt[c] == T1H)};
                    bitn[c]++;
                    if (bitn[c] == BITS) begin
                        bitn[c] = 0;
                        chk(expq[c].size() != 0, "word_expected", expq[c].size(), 1);
                        if (expq[c].size() != 0) begin
                            mon_e = expq[c].pop_front();
                            chk(acc[c] == mon_e[31:8], "word_data", longint'(acc[c]), longint'(mon_e[31:8]));
                        end
                    end
                end
                prevd[c] = dout[c];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_push(input int c, input logic [31:0] w, input bit expect_accept);
        ch   = 2'(c);
        din  = w;
        push = 1'b1;
        if (expect_accept) expq[c].push_back(w);
        step();
        push = 1'b0;
    endtask

    task automatic wait_rises(input int c, input int n, input string name);
        int t = 0;
        while (rises[c] < n && t < LIMIT) begin
            step();
            t++;
        end
        if (rises[c] < n) chk(1'b0, name, rises[c], n);
    endtask

    task automatic wait_idle(input int c, output int when);
        int t = 0;
        while (busy[c] && t < LIMIT) begin
            step();
            t++;
        end
        when = cyc;
        if (busy[c]) chk(1'b0, "idle_timeout", c, 0);
    endtask

    typedef struct {
        logic [31:0] w;
        bit          accept;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_empty;
    } vec_t;

    vec_t tab [6];

    int base, pe, first, lastr, tf, others, bad, r;
    logic d0p;

    initial begin
        tab[0] = '{32'h11111100, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[1] = '{32'h22222200, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2] = '{32'h33333300, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[3] = '{32'h44444400, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{32'h55555500, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[5] = '{32'h66666600, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) step();
        chk(dout == 4'h0,    "reset_dout",  dout, 0);
        chk(dout_i == 4'hF,  "reset_dout_inv", dout_i, 15);
        chk(empty == 4'hF,   "reset_empty", empty, 15);
        chk(full == 4'h0,    "reset_full",  full, 0);
        chk(busy == 4'h0,    "reset_busy",  busy, 0);
        chk(ovf == 4'h0,     "reset_ovf",   ovf, 0);
        reset = 1'b0;
        step();

        // Single GRB word on ch0.
        base = rises[0];
        others = rises[1] + rises[2] + rises[3];
        do_push(0, 32'hff00ff00, 1'b1);
        pe = cyc;
        chk(empty[0] == 1'b0, "push_empty", empty[0], 0);
        wait_rises(0, base + 1, "t1_first_rise");
        chk(last_rise[0] == pe + 2, "t1_latency", last_rise[0] - pe, 2);
        wait_rises(0, base + BITS, "t1_all_bits");
        lastr = last_rise[0];
        wait_idle(0, tf);
        chk(tf == lastr + TBIT + TRESET, "t1_latch_end", tf - lastr, TBIT + TRESET);
        chk(rises[1] + rises[2] + rises[3] == others, "t1_quiet_others", rises[1] + rises[2] + rises[3] - others, 0);
        chk(expq[0].size() == 0, "t1_words_left", expq[0].size(), 0);

        // Two back-to-back words on ch1 chain without a gap.
        base = rises[1];
        do_push(1, 32'h80000000, 1'b1);
        do_push(1, 32'h00000100, 1'b1);
        wait_rises(1, base + 1, "t2_first_rise");
        first = last_rise[1];
        wait_rises(1, base + 2 * BITS, "t2_all_bits");
        lastr = last_rise[1];
        chk(lastr - first == (2 * BITS - 1) * TBIT, "t2_chain_span", lastr - first, (2 * BITS - 1) * TBIT);
        wait_idle(1, tf);
        chk(tf == lastr + TBIT + TRESET, "t2_latch_end", tf - lastr, TBIT + TRESET);
        chk(expq[1].size() == 0, "t2_words_left", expq[1].size(), 0);

        // Overflow on ch2, table-driven.
        base = rises[2];
        for (int i = 0; i < 6; i++) begin
            do_push(2, tab[i].w, tab[i].accept);
            chk(full[2] == tab[i].exp_full,   $sformatf("t3_full_%0d", i),  full[2], tab[i].exp_full);
            chk(ovf[2] == tab[i].exp_ovf,     $sformatf("t3_ovf_%0d", i),   ovf[2], tab[i].exp_ovf);
            chk(empty[2] == tab[i].exp_empty, $sformatf("t3_empty_%0d", i), empty[2], tab[i].exp_empty);
        end
        chk(full[1:0] == 2'b00 && full[3] == 1'b0, "t3_full_others", full, 4);
        wait_rises(2, base + 5 * BITS, "t3_all_bits");
        wait_idle(2, tf);
        chk(rises[2] - base == 5 * BITS, "t3_bit_count", rises[2] - base, 5 * BITS);
        chk(expq[2].size() == 0, "t3_words_left", expq[2].size(), 0);
        chk(empty[2] == 1'b1, "t3_empty_end", empty[2], 1);

        // ch3 one clock behind ch0 with the same word.
        do_push(0, 32'h5ac3e700, 1'b1);
        do_push(3, 32'h5ac3e700, 1'b1);
        chk(busy[1] == 1'b0 && busy[2] == 1'b0 && empty[1] && empty[2], "t4_independent", busy, 0);
        bad = 0;
        d0p = dout[0];
        for (int i = 0; i < BITS * TBIT + TRESET + 6; i++) begin
            step();
            if (dout[3] !== d0p) bad++;
            d0p = dout[0];
        end
        chk(bad == 0, "t4_delay_match", bad, 0);
        wait_idle(0, tf);
        wait_idle(3, tf);
        chk(expq[0].size() == 0 && expq[3].size() == 0, "t4_words_left", expq[0].size() + expq[3].size(), 0);

        // Push during LATCH: gap is not shortened.
        base = rises[1];
        do_push(1, 32'hc0ffee00, 1'b1);
        wait_rises(1, base + BITS, "t6_first_word");
        r = last_rise[1];
        repeat (10) step();
        do_push(1, 32'h0badf000, 1'b1);
        chk(busy[1] == 1'b1, "t6_busy_in_latch", busy[1], 1);
        wait_rises(1, base + BITS + 1, "t6_second_rise");
        chk(last_rise[1] - r == TBIT + TRESET + 1, "t6_latch_gap", last_rise[1] - r, TBIT + TRESET + 1);
        wait_rises(1, base + 2 * BITS, "t6_second_word");
        wait_idle(1, tf);
        chk(expq[1].size() == 0, "t6_words_left", expq[1].size(), 0);

        // Reset in the HIGH phase of bit 5.
        chk(ovf == 4'b0100, "t5_ovf_before", ovf, 4);
        base = rises[0];
        do_push(0, 32'hffffff00, 1'b1);
        do_push(0, 32'h12345600, 1'b1);
        wait_rises(0, base + 6, "t5_bit5");
        reset = 1'b1;
        step();
        chk(dout == 4'h0,   "t5_dout",     dout, 0);
        chk(dout_i == 4'hF, "t5_dout_inv", dout_i, 15);
        chk(empty == 4'hF,  "t5_empty",    empty, 15);
        chk(ovf == 4'h0,    "t5_ovf",      ovf, 0);
        chk(busy == 4'h0,   "t5_busy",     busy, 0);
        reset = 1'b0;
        step();
        base = rises[0];
        do_push(0, 32'h9a3c7100, 1'b1);
        pe = cyc;
        wait_rises(0, base + 1, "t5_fresh_rise");
        chk(last_rise[0] == pe + 2, "t5_latency", last_rise[0] - pe, 2);
        wait_rises(0, base + BITS, "t5_fresh_bits");
        wait_idle(0, tf);
        chk(expq[0].size() == 0, "t5_words_left", expq[0].size(), 0);

        chk(inv_bad == 0, "invert_mirror", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
